wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set per-requester queue depth in entries (power of two, 2..8).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the contention counter.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  SHALL be the reset: synchronous, active-low, sampled only on the rising edge of CLK.
REQ-005 A_valid  input  1  SHALL indicate that requester A (ALU writeback) presents a write.
REQ-006 A_reg  input  5  SHALL carry A's destination register index.
REQ-007 A_data  input  32  SHALL carry A's write data.
REQ-008 A_ready  output  1  SHALL indicate that A's queue can accept an entry this cycle.
REQ-009 B_valid, B_reg, B_data, B_ready  SHALL be the same as REQ-005..008 for requester B (load unit).
REQ-010 RegWrite  output  1  SHALL be the registered write enable for the register-file write port.
REQ-011 WriteReg  output  5  SHALL be the registered write index.
REQ-012 WriteData  output  32  SHALL be the registered write data.
REQ-013 Grant  output  1  SHALL identify the source of the current write: 0 = A, 1 = B; meaningful only while RegWrite=1.
REQ-014 Contention  output  CNT_W  SHALL count cycles in which both queue heads were non-empty.

Function
REQ-015 Each requester SHALL have its own FIFO of DEPTH entries holding {reg, data}.
REQ-016 X_ready SHALL equal "queue X not full", computed from registered state only, with no combinational path from any input.
REQ-017 An entry SHALL be enqueued on a rising edge where X_valid=1 and X_ready=1; X_valid=1 with X_ready=0 SHALL be ignored, and the requester holds its request.
REQ-018 A write with X_reg=0 SHALL be accepted (handshake completes) but not enqueued, and SHALL never produce RegWrite.
REQ-019 At most one entry SHALL be dequeued per cycle and driven onto RegWrite/WriteReg/WriteData/Grant on the next rising edge (latency: enqueue edge to RegWrite high is at least 2 edges).
REQ-020 With only one queue non-empty, that queue SHALL be served.
REQ-021 With both queues non-empty, the requester not served most recently SHALL win (round-robin); the last-served pointer SHALL reset to B, so A wins the first tie.
REQ-022 In a cycle with no dequeue, RegWrite SHALL be 0 and WriteReg/WriteData/Grant SHALL hold their previous values.
REQ-023 Enqueue and dequeue on the same queue in the same cycle SHALL both take effect: occupancy unchanged, and a full queue SHALL NOT raise ready in that cycle.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH or drop below 0.
REQ-025 Entries from one requester SHALL be written in acceptance order; no ordering is guaranteed between A and B.
REQ-026 Contention SHALL increment by 1 in each cycle with both queues non-empty, and SHALL saturate at all ones.

Reset
REQ-027 While RESET=0 at a rising edge, the block SHALL flush both queues and clear RegWrite, WriteReg, WriteData, Grant, Contention and the round-robin state (last-served = B).
REQ-028 In the cycle after reset, A_ready and B_ready SHALL be 1.
REQ-029 A RESET pulse during operation SHALL discard all queued writes; no discarded write SHALL appear on RegWrite afterwards.
REQ-030 Inputs sampled in the same edge as RESET=0 SHALL be ignored.

Verification
REQ-031 Single A write, reg 5, data 0xDEADBEEF -> two edges later RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF, Grant=0 for exactly one cycle.
REQ-032 A and B valid every cycle (A regs 1,2,3; B regs 11,12,13) -> grants alternate A,B,A,B,A,B; Contention counts each overlap cycle.
REQ-033 B_valid held high while the write port is stalled by A-only traffic, with DEPTH=2 -> B_ready falls after 2 accepts; no entry is lost or duplicated; B order is preserved.
REQ-034 A write with reg 0, data 0xFFFFFFFF -> A_ready handshake completes; RegWrite stays 0.
REQ-035 Fill both queues, then RESET=0 for one edge -> all outputs 0, both ready=1, and no RegWrite pulses in the following 4 cycles.
REQ-036 CNT_W=4 with 20 cycles of continuous contention -> Contention saturates at 15.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-requester register-file write arbiter.
// Per-source FIFOs, round-robin on ties, registered write port.
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             A_valid,
  input  logic [4:0]       A_reg,
  input  logic [31:0]      A_data,
  output logic             A_ready,
  input  logic             B_valid,
  input  logic [4:0]       B_reg,
  input  logic [31:0]      B_data,
  output logic             B_ready,
  output logic             RegWrite,
  output logic [4:0]       WriteReg,
  output logic [31:0]      WriteData,
  output logic             Grant,
  output logic [CNT_W-1:0] Contention
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [36:0]   a_mem [DEPTH];
  logic [36:0]   b_mem [DEPTH];
  logic [AW-1:0] a_wp, a_rp, b_wp, b_rp;
  logic [AW:0]   a_cnt, b_cnt;
  logic          last_b;

  logic a_ne, b_ne;
  logic a_push, b_push;
  logic a_pop, b_pop;
  logic [36:0] a_head, b_head;

  assign A_ready = (a_cnt != FULL);
  assign B_ready = (b_cnt != FULL);
  assign a_ne    = (a_cnt != '0);
  assign b_ne    = (b_cnt != '0);

  // Writes to x0 complete the handshake but are dropped here.
  assign a_push = A_valid && A_ready && (A_reg != 5'd0);
  assign b_push = B_valid && B_ready && (B_reg != 5'd0);

  // A wins unless B is alone or A was served last.
  assign a_pop  = a_ne && (!b_ne || last_b);
  assign b_pop  = b_ne && !a_pop;
  assign a_head = a_mem[a_rp];
  assign b_head = b_mem[b_rp];

  // Entry storage; reset flushes via pointers, so no clear here.
  always_ff @(posedge CLK) begin
    if (a_push) a_mem[a_wp] <= {A_reg, A_data};
    if (b_push) b_mem[b_wp] <= {B_reg, B_data};
  end

  // Queue A pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      a_wp  <= '0;
      a_rp  <= '0;
      a_cnt <= '0;
    end else begin
      if (a_push) a_wp <= a_wp + AW'(1);
      if (a_pop)  a_rp <= a_rp + AW'(1);
      a_cnt <= a_cnt + {{AW{1'b0}}, a_push}
                     - {{AW{1'b0}}, a_pop};
    end
  end

  // Queue B pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      b_wp  <= '0;
      b_rp  <= '0;
      b_cnt <= '0;
    end else begin
      if (b_push) b_wp <= b_wp + AW'(1);
      if (b_pop)  b_rp <= b_rp + AW'(1);
      b_cnt <= b_cnt + {{AW{1'b0}}, b_push}
                     - {{AW{1'b0}}, b_pop};
    end
  end

  // Registered write port; fields hold when nothing is dequeued.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      Grant     <= 1'b0;
      last_b    <= 1'b1;
    end else begin
      RegWrite <= a_pop || b_pop;
      if (a_pop || b_pop) begin
        Grant     <= b_pop;
        last_b    <= b_pop;
        WriteReg  <= b_pop ? b_head[36:32] : a_head[36:32];
        WriteData <= b_pop ? b_head[31:0]  : a_head[31:0];
      end
    end
  end

  // Saturating count of cycles with both heads waiting.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      Contention <= '0;
    end else if (a_ne && b_ne && (Contention != '1)) begin
      Contention <= Contention + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter.
// Second instance uses a 4-bit contention counter.
module tb_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        A_valid, B_valid;
  logic [4:0]  A_reg, B_reg;
  logic [31:0] A_data, B_data;
  logic        A_ready, B_ready;
  logic        RegWrite, Grant;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [15:0] Contention;

  logic        a_ready2, b_ready2, regwrite2, grant2;
  logic [4:0]  writereg2;
  logic [31:0] writedata2;
  logic [3:0]  contention2;

  int checks = 0;
  int errors = 0;
  int bstall;
  logic [37:0] log_q [$];

  always #5 CLK = ~CLK;

  wb_arbiter #(.DEPTH(2), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .A_valid(A_valid), .A_reg(A_reg), .A_data(A_data),
    .A_ready(A_ready),
    .B_valid(B_valid), .B_reg(B_reg), .B_data(B_data),
    .B_ready(B_ready),
    .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .Grant(Grant),
    .Contention(Contention)
  );

  wb_arbiter #(.DEPTH(2), .CNT_W(4)) dut2 (
    .CLK(CLK), .RESET(RESET),
    .A_valid(A_valid), .A_reg(A_reg), .A_data(A_data),
    .A_ready(a_ready2),
    .B_valid(B_valid), .B_reg(B_reg), .B_data(B_data),
    .B_ready(b_ready2),
    .RegWrite(regwrite2), .WriteReg(writereg2),
    .WriteData(writedata2), .Grant(grant2),
    .Contention(contention2)
  );

  always @(negedge CLK)
    if (RegWrite) log_q.push_back({Grant, WriteReg, WriteData});

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET   = 1'b0;
    A_valid = 1'b0;
    B_valid = 1'b0;
    tick();
    RESET = 1'b1;
  endtask

  task automatic stream(input int na, input int nb,
                        input int abase, input int bbase);
    int ia = 0;
    int ib = 0;
    int cyc = 0;
    logic fa, fb;
    bstall = -1;
    while ((ia < na || ib < nb) && cyc < 100) begin
      A_valid = (ia < na);
      A_reg   = 5'(abase + ia);
      A_data  = 32'hA000_0000 | 32'(ia);
      B_valid = (ib < nb);
      B_reg   = 5'(bbase + ib);
      B_data  = 32'hB000_0000 | 32'(ib);
      @(negedge CLK);
      if (B_valid && !B_ready && bstall < 0) bstall = ib;
      fa = A_valid && A_ready;
      fb = B_valid && B_ready;
      tick();
      if (fa) ia++;
      if (fb) ib++;
      cyc++;
    end
    A_valid = 1'b0;
    B_valid = 1'b0;
    check("stream_done", 64'(cyc < 100), 64'd1);
  endtask

  initial begin
    int ai, bi;
    int exp_reg [6];
    int exp_gnt [6];
    exp_reg = '{1, 11, 2, 12, 3, 13};
    exp_gnt = '{0, 1, 0, 1, 0, 1};
    A_valid = 0; A_reg = 0; A_data = 0;
    B_valid = 0; B_reg = 0; B_data = 0;
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;

    @(negedge CLK);
    check("rst_regwrite", 64'(RegWrite), 64'd0);
    check("rst_writereg", 64'(WriteReg), 64'd0);
    check("rst_writedata", 64'(WriteData), 64'd0);
    check("rst_grant", 64'(Grant), 64'd0);
    check("rst_cont", 64'(Contention), 64'd0);
    check("rst_a_ready", 64'(A_ready), 64'd1);
    check("rst_b_ready", 64'(B_ready), 64'd1);

    tick();
    A_valid = 1; A_reg = 5; A_data = 32'hDEAD_BEEF;
    tick();
    A_valid = 0;
    @(negedge CLK);
    check("lat1_regwrite", 64'(RegWrite), 64'd0);
    @(negedge CLK);
    check("single_regwrite", 64'(RegWrite), 64'd1);
    check("single_reg", 64'(WriteReg), 64'd5);
    check("single_data", 64'(WriteData), 64'hDEAD_BEEF);
    check("single_grant", 64'(Grant), 64'd0);
    @(negedge CLK);
    check("single_pulse", 64'(RegWrite), 64'd0);
    check("hold_reg", 64'(WriteReg), 64'd5);

    log_q.delete();
    tick();
    A_valid = 1; A_reg = 0; A_data = 32'hFFFF_FFFF;
    @(negedge CLK);
    check("x0_ready", 64'(A_ready), 64'd1);
    tick();
    A_valid = 0;
    repeat (3) begin
      @(negedge CLK);
      check("x0_no_write", 64'(RegWrite), 64'd0);
    end
    check("x0_hold_data", 64'(WriteData), 64'hDEAD_BEEF);
    check("x0_log", 64'(log_q.size()), 64'd0);

    do_reset();
    log_q.delete();
    stream(3, 3, 1, 11);
    repeat (6) tick();
    check("rr_count", 64'(log_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      check("rr_grant", 64'(log_q[i][37]), 64'(exp_gnt[i]));
      check("rr_reg", 64'(log_q[i][36:32]), 64'(exp_reg[i]));
    end
    check("rr_cont", 64'(Contention), 64'd5);
    check("rr_cont4", 64'(contention2), 64'd5);

    do_reset();
    log_q.delete();
    stream(6, 6, 1, 21);
    repeat (10) tick();
    check("b_stall_at", 64'(bstall), 64'd2);
    ai = 0;
    bi = 0;
    foreach (log_q[i]) begin
      if (log_q[i][37]) begin
        check("b_order_reg", 64'(log_q[i][36:32]), 64'(21 + bi));
        check("b_order_data", 64'(log_q[i][31:0]),
              64'(32'hB000_0000 | 32'(bi)));
        bi++;
      end else begin
        check("a_order_reg", 64'(log_q[i][36:32]), 64'(1 + ai));
        check("a_order_data", 64'(log_q[i][31:0]),
              64'(32'hA000_0000 | 32'(ai)));
        ai++;
      end
    end
    check("a_total", 64'(ai), 64'd6);
    check("b_total", 64'(bi), 64'd6);

    A_valid = 1; A_reg = 3; A_data = 32'h1111_1111;
    B_valid = 1; B_reg = 4; B_data = 32'h2222_2222;
    repeat (4) tick();
    A_reg = 7;
    B_reg = 8;
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    A_valid = 0;
    B_valid = 0;
    log_q.delete();
    @(negedge CLK);
    check("flush_regwrite", 64'(RegWrite), 64'd0);
    check("flush_writereg", 64'(WriteReg), 64'd0);
    check("flush_writedata", 64'(WriteData), 64'd0);
    check("flush_grant", 64'(Grant), 64'd0);
    check("flush_cont", 64'(Contention), 64'd0);
    check("flush_a_ready", 64'(A_ready), 64'd1);
    check("flush_b_ready", 64'(B_ready), 64'd1);
    repeat (4) @(negedge CLK);
    check("flush_no_write", 64'(log_q.size()), 64'd0);

    do_reset();
    A_valid = 1; A_reg = 9; A_data = 32'h9;
    B_valid = 1; B_reg = 10; B_data = 32'hA;
    repeat (21) tick();
    A_valid = 0;
    B_valid = 0;
    @(negedge CLK);
    check("cont16", 64'(Contention), 64'd20);
    check("cont4_sat", 64'(contention2), 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
